// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared defaults and types for the SPI TX/RX FIFO stage.
//   SPI_FIFO_DW_DEF    - default word width
//   SPI_FIFO_DEPTH_DEF - default entries per FIFO
//   SPI_FIFO_LVL_W_MAX - width of the level field carried in the status struct
//   spi_fifo_status_t  - per-FIFO status: empty, full, level, overflow, underflow
package spi_fifo_pkg;

  localparam int unsigned SPI_FIFO_DW_DEF    = 16;
  localparam int unsigned SPI_FIFO_DEPTH_DEF = 8;
  // Status level is zero-extended to a fixed width; DEPTH must stay below 2^15.
  localparam int unsigned SPI_FIFO_LVL_W_MAX = 16;

  typedef struct packed {
    logic                          empty;
    logic                          full;
    logic [SPI_FIFO_LVL_W_MAX-1:0] level;
    logic                          overflow;
    logic                          underflow;
  } spi_fifo_status_t;

  function automatic int unsigned spi_fifo_lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_txrx_fifo_if.sv
// spi_txrx_fifo_if: engine-side signals of the SPI FIFO stage.
//   tx_valid/tx_ready/tx_data - TX head word offered to the shift engine
//   rx_wr_en/rx_wr_data       - received word pushed by the shift engine
// Modports: master = shift engine, slave = FIFO stage.
interface spi_txrx_fifo_if
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_FIFO_DW_DEF
);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_wr_en;
  logic [DATA_WIDTH-1:0] rx_wr_data;

  modport master (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_wr_en,
    output rx_wr_data
  );

  modport slave (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_wr_en,
    input  rx_wr_data
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_spi, rst_spi   - clock, synchronous active-high reset
//   push, push_data    - write request; dropped when full without a same-cycle pop
//   pop, pop_data      - read request; pop_data is the head word (0 when empty)
//   flush              - clears both pointers, overrides push/pop silently
//   status             - empty/full/level from registered pointers, registered
//                        overflow/underflow pulses
module spi_sync_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_FIFO_DW_DEF,
  parameter int unsigned DEPTH      = SPI_FIFO_DEPTH_DEF
) (
  input  logic                  clk_spi,
  input  logic                  rst_spi,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  flush,
  output spi_fifo_status_t      status
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Extra MSB is the wrap bit distinguishing full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        empty, full;
  logic        pop_ok, push_ok;
  logic [AW:0] level;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
      ovf_d = push && !push_ok;
      udf_d = pop && empty;
    end
  end

  always_ff @(posedge clk_spi) begin
    if (rst_spi) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_spi) begin
    if (push_ok && !flush) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    status           = '0;
    status.empty     = empty;
    status.full      = full;
    status.level     = {{(SPI_FIFO_LVL_W_MAX - AW - 1){1'b0}}, level};
    status.overflow  = ovf_q;
    status.underflow = udf_q;
  end

endmodule

// File: rtl/spi_txrx_fifo.sv
// spi_txrx_fifo: TX/RX buffering between the APB register file and the SPI
// shift engine, single clock domain (clk_spi).
//   clk_spi, rst_spi            - clock, synchronous active-high reset
//   tx_wr_en, tx_wr_data        - host push into TX FIFO
//   eng (spi_txrx_fifo_if.slave)- TX valid/ready/data to engine, RX push from engine
//   rx_rd_en, rx_rd_data        - host pop from RX FIFO (FWFT head word)
//   tx_flush, rx_flush          - clear the addressed FIFO
//   tx_thr, rx_thr              - low/high-water thresholds
//   tx_level, rx_level, *_empty, *_full - occupancy status
//   tx_overflow, rx_overflow, rx_underflow - one-cycle error pulses
//   tx_below_thr, rx_above_thr  - registered threshold flags
// Build option: SPI_FIFO_THRESH_EN enables the threshold flags; otherwise they
// are tied to 0 and the threshold inputs are ignored.
module spi_txrx_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_FIFO_DW_DEF,
  parameter int unsigned DEPTH      = SPI_FIFO_DEPTH_DEF,
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk_spi,
  input  logic                  rst_spi,
  input  logic                  tx_wr_en,
  input  logic [DATA_WIDTH-1:0] tx_wr_data,
  spi_txrx_fifo_if.slave        eng,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_rd_data,
  input  logic                  tx_flush,
  input  logic                  rx_flush,
  input  logic [LVL_W-1:0]      tx_thr,
  input  logic [LVL_W-1:0]      rx_thr,
  output logic [LVL_W-1:0]      tx_level,
  output logic [LVL_W-1:0]      rx_level,
  output logic                  tx_empty,
  output logic                  tx_full,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic                  tx_overflow,
  output logic                  rx_overflow,
  output logic                  rx_underflow,
  output logic                  tx_below_thr,
  output logic                  rx_above_thr
);

  spi_fifo_status_t tx_st, rx_st;

  // The FIFO only pops when non-empty, so tx_ready maps straight onto pop.
  spi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_tx_fifo (
    .clk_spi   (clk_spi),
    .rst_spi   (rst_spi),
    .push      (tx_wr_en),
    .push_data (tx_wr_data),
    .pop       (eng.tx_ready),
    .pop_data  (eng.tx_data),
    .flush     (tx_flush),
    .status    (tx_st)
  );

  spi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rx_fifo (
    .clk_spi   (clk_spi),
    .rst_spi   (rst_spi),
    .push      (eng.rx_wr_en),
    .push_data (eng.rx_wr_data),
    .pop       (rx_rd_en),
    .pop_data  (rx_rd_data),
    .flush     (rx_flush),
    .status    (rx_st)
  );

  assign eng.tx_valid = !tx_st.empty;
  assign tx_level     = tx_st.level[LVL_W-1:0];
  assign rx_level     = rx_st.level[LVL_W-1:0];
  assign tx_empty     = tx_st.empty;
  assign tx_full      = tx_st.full;
  assign rx_empty     = rx_st.empty;
  assign rx_full      = rx_st.full;
  assign tx_overflow  = tx_st.overflow;
  assign rx_overflow  = rx_st.overflow;
  assign rx_underflow = rx_st.underflow;

`ifdef SPI_FIFO_THRESH_EN
  logic tx_below_q, rx_above_q;

  // Flags follow the registered levels one cycle later; reset value reflects
  // an empty FIFO (0 <= any tx_thr, rx level never >= a non-zero threshold).
  always_ff @(posedge clk_spi) begin
    if (rst_spi) begin
      tx_below_q <= 1'b1;
      rx_above_q <= 1'b0;
    end else begin
      tx_below_q <= (tx_level <= tx_thr);
      rx_above_q <= (rx_level >= rx_thr) && (rx_thr != '0);
    end
  end

  assign tx_below_thr = tx_below_q;
  assign rx_above_thr = rx_above_q;

  logic unused_status;
  assign unused_status = ^{tx_st.underflow, tx_st.level[SPI_FIFO_LVL_W_MAX-1:LVL_W],
                           rx_st.level[SPI_FIFO_LVL_W_MAX-1:LVL_W]};
`else
  assign tx_below_thr = 1'b0;
  assign rx_above_thr = 1'b0;

  logic unused_status;
  assign unused_status = ^{tx_thr, rx_thr, tx_st.underflow,
                           tx_st.level[SPI_FIFO_LVL_W_MAX-1:LVL_W],
                           rx_st.level[SPI_FIFO_LVL_W_MAX-1:LVL_W]};
`endif

endmodule
